adma_dm_axi_r_mc: RTL and testbench

// Multi-channel AXI read-data receiver for the DMA data mover, successor to the single-stream R path.

---
 rtl/adma_dm_axi_r_mc.sv | 174 +++++++++++++++++
 tb/tb_adma_dm_axi_r_mc.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adma_dm_axi_r_mc.sv
// rtl/adma_dm_axi_r_mc.sv - multi-channel AXI R receiver: per-channel burst length queues, beat demux, sticky errors
// Optional macro ADMA_R_OUT_PIPE_EN adds a 2-entry skid on out_* and cuts the out_rdy -> m_rready_o path.
module adma_dm_axi_r_mc #(
   parameter int DMA_CHN_NUM  = 4,
   parameter int MST_ID_W     = 5,
   parameter int ATX_LEN_W    = 8,
   parameter int ATX_DATA_W   = 256,
   parameter int OSTD_PER_CHN = 2,
   parameter int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM)
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic [DMA_CHN_NUM_W-1:0]                          atx_chn_id,
   input  logic [ATX_LEN_W-1:0]                              atx_arlen,
   input  logic                                              atx_vld,
   output logic                                              atx_rdy,
   input  logic [MST_ID_W-1:0]                               m_rid_i,
   input  logic [ATX_DATA_W-1:0]                             m_rdata_i,
   input  logic [1:0]                                        m_rresp_i,
   input  logic                                              m_rlast_i,
   input  logic                                              m_rvalid_i,
   output logic                                              m_rready_o,
   output logic [DMA_CHN_NUM_W-1:0]                          out_chn_id,
   output logic [ATX_DATA_W-1:0]                             out_rdata,
   output logic                                              out_last,
   output logic                                              out_vld,
   input  logic                                              out_rdy,
   output logic [DMA_CHN_NUM*($clog2(OSTD_PER_CHN)+1)-1:0]   chn_ostd,
   output logic [DMA_CHN_NUM*2-1:0]                          chn_err,
   input  logic [DMA_CHN_NUM-1:0]                            err_clr
);

   localparam int CHN_W = DMA_CHN_NUM_W;
   localparam int OW    = $clog2(OSTD_PER_CHN) + 1;
   localparam int PW    = (OSTD_PER_CHN > 1) ? $clog2(OSTD_PER_CHN) : 1;

   logic [OW-1:0]        q_cnt    [DMA_CHN_NUM];
   logic [PW-1:0]        q_wp     [DMA_CHN_NUM];
   logic [PW-1:0]        q_rp     [DMA_CHN_NUM];
   logic [ATX_LEN_W-1:0] q_len    [DMA_CHN_NUM][OSTD_PER_CHN];
   logic [ATX_LEN_W-1:0] beat_cnt [DMA_CHN_NUM];
   logic [1:0]           err_q    [DMA_CHN_NUM];

   logic [DMA_CHN_NUM-1:0] full_v, push_v, pop_v, fwd_v, acc_v;
   logic [CHN_W-1:0]       r_ch;
   logic [ATX_LEN_W-1:0]   head_len;
   logic                   r_exp, r_exp_last, r_acc, r_fwd, r_pop, atx_push, fwd_rdy;
   logic [1:0]             r_code;
   logic                   unused_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(OSTD_PER_CHN - 1)) ? '0 : p + PW'(1);
   endfunction

   assign unused_ok  = ^{m_rid_i, m_rresp_i[0]};
   assign r_ch       = m_rid_i[CHN_W-1:0];
   assign r_exp      = (q_cnt[r_ch] != '0);
   assign head_len   = q_len[r_ch][q_rp[r_ch]];
   assign r_exp_last = (beat_cnt[r_ch] == head_len);

   // Beats for a channel with nothing queued never wait on the output side.
   assign m_rready_o = ~rst & (fwd_rdy | ~r_exp);
   assign r_acc      = m_rvalid_i & m_rready_o;
   assign r_fwd      = r_acc & r_exp;
   assign r_pop      = r_fwd & r_exp_last;

   always_comb begin
      r_code = 2'b00;
      if (!r_exp)
         r_code = 2'b11;
      else if (m_rlast_i != r_exp_last)
         r_code = 2'b10;
      else if (m_rresp_i[1])
         r_code = 2'b01;
   end

   // A full queue still takes a record when its head retires in the same cycle.
   assign atx_rdy  = ~rst & (~full_v[atx_chn_id] | (r_pop & (r_ch == atx_chn_id)));
   assign atx_push = atx_vld & atx_rdy;

   always_comb begin
      full_v   = '0;
      push_v   = '0;
      pop_v    = '0;
      fwd_v    = '0;
      acc_v    = '0;
      chn_ostd = '0;
      chn_err  = '0;
      for (int c = 0; c < DMA_CHN_NUM; c++) begin
         full_v[c]           = (q_cnt[c] == OW'(OSTD_PER_CHN));
         push_v[c]           = atx_push & (atx_chn_id == CHN_W'(c));
         pop_v[c]            = r_pop & (r_ch == CHN_W'(c));
         fwd_v[c]            = r_fwd & (r_ch == CHN_W'(c));
         acc_v[c]            = r_acc & (r_ch == CHN_W'(c));
         chn_ostd[c*OW +: OW] = q_cnt[c];
         chn_err[c*2 +: 2]    = err_q[c];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < DMA_CHN_NUM; c++) begin
            q_cnt[c]    <= '0;
            q_wp[c]     <= '0;
            q_rp[c]     <= '0;
            beat_cnt[c] <= '0;
            err_q[c]    <= 2'b00;
         end
      end else begin
         for (int c = 0; c < DMA_CHN_NUM; c++) begin
            if (push_v[c]) begin
               q_len[c][q_wp[c]] <= atx_arlen;
               q_wp[c]           <= ptr_inc(q_wp[c]);
            end
            if (pop_v[c])
               q_rp[c] <= ptr_inc(q_rp[c]);
            if (push_v[c] && !pop_v[c])
               q_cnt[c] <= q_cnt[c] + OW'(1);
            else if (!push_v[c] && pop_v[c])
               q_cnt[c] <= q_cnt[c] - OW'(1);
            // The burst ends on the counter, whatever RLAST says.
            if (fwd_v[c])
               beat_cnt[c] <= r_exp_last ? '0 : beat_cnt[c] + ATX_LEN_W'(1);
            if (acc_v[c] && (r_code != 2'b00) && ((err_q[c] == 2'b00) || err_clr[c]))
               err_q[c] <= r_code;
            else if (err_clr[c])
               err_q[c] <= 2'b00;
         end
      end
   end

`ifdef ADMA_R_OUT_PIPE_EN
   logic [ATX_DATA_W-1:0] sk_data [2];
   logic [CHN_W-1:0]      sk_chn  [2];
   logic                  sk_last [2];
   logic [1:0]            sk_cnt;
   logic                  sk_wp, sk_rp, sk_pop;

   assign fwd_rdy    = (sk_cnt != 2'd2);
   assign sk_pop     = out_vld & out_rdy;
   assign out_vld    = (sk_cnt != 2'd0);
   assign out_chn_id = sk_chn[sk_rp];
   assign out_rdata  = sk_data[sk_rp];
   assign out_last   = sk_last[sk_rp];

   always_ff @(posedge clk) begin
      if (rst) begin
         sk_cnt <= 2'd0;
         sk_wp  <= 1'b0;
         sk_rp  <= 1'b0;
      end else begin
         if (r_fwd) begin
            sk_data[sk_wp] <= m_rdata_i;
            sk_chn[sk_wp]  <= r_ch;
            sk_last[sk_wp] <= r_exp_last;
            sk_wp          <= ~sk_wp;
         end
         if (sk_pop)
            sk_rp <= ~sk_rp;
         if (r_fwd && !sk_pop)
            sk_cnt <= sk_cnt + 2'd1;
         else if (!r_fwd && sk_pop)
            sk_cnt <= sk_cnt - 2'd1;
      end
   end
`else
   assign fwd_rdy    = out_rdy;
   assign out_vld    = ~rst & m_rvalid_i & r_exp;
   assign out_chn_id = r_ch;
   assign out_rdata  = m_rdata_i;
   assign out_last   = r_exp_last;
`endif

endmodule

// File: tb/tb_adma_dm_axi_r_mc.sv
// tb/tb_adma_dm_axi_r_mc.sv - directed scoreboard bench for adma_dm_axi_r_mc
module tb_adma_dm_axi_r_mc;

   localparam int N = 4, CW = 2, IW = 5, LW = 8, DW = 256, OW = 2;
   typedef logic [CW+DW:0] sb_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [CW-1:0]  atx_chn_id;
   logic [LW-1:0]  atx_arlen;
   logic           atx_vld, atx_rdy;
   logic [IW-1:0]  m_rid_i;
   logic [DW-1:0]  m_rdata_i;
   logic [1:0]     m_rresp_i;
   logic           m_rlast_i, m_rvalid_i, m_rready_o;
   logic [CW-1:0]  out_chn_id;
   logic [DW-1:0]  out_rdata;
   logic           out_last, out_vld, out_rdy;
   logic [N*OW-1:0] chn_ostd;
   logic [N*2-1:0]  chn_err;
   logic [N-1:0]    err_clr;

   int  checks = 0;
   int  errors = 0;
   sb_t sb[$];
   int  sent;

   adma_dm_axi_r_mc dut (
      .clk(clk), .rst(rst),
      .atx_chn_id(atx_chn_id), .atx_arlen(atx_arlen), .atx_vld(atx_vld), .atx_rdy(atx_rdy),
      .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rlast_i(m_rlast_i),
      .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
      .out_chn_id(out_chn_id), .out_rdata(out_rdata), .out_last(out_last),
      .out_vld(out_vld), .out_rdy(out_rdy),
      .chn_ostd(chn_ostd), .chn_err(chn_err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] err_of(input int c);
      return chn_err[c*2 +: 2];
   endfunction

   function automatic logic [OW-1:0] ostd_of(input int c);
      return chn_ostd[c*OW +: OW];
   endfunction

   // Scoreboard consumer: every output handshake must match the oldest expected beat.
   always @(negedge clk) begin
      if (!rst && out_vld && out_rdy) begin
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_out observed=%0h expected=none", {out_chn_id, out_last});
         end
         if (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            checks++;
            assert ({out_chn_id, out_rdata, out_last} === e) else begin
               errors++;
               $error("FAIL out_beat observed=ch%0d last%0d expected=ch%0d last%0d",
                      out_chn_id, out_last, e[CW+DW:DW+1], e[0]);
            end
         end
      end
   end

   task automatic ar_push(input int c, input int len);
      logic ok;
      ok = 1'b0;
      atx_chn_id = CW'(c);
      atx_arlen  = LW'(len);
      atx_vld    = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = atx_rdy;
         if (!ok) @(posedge clk);
      end
      @(posedge clk); #1;
      atx_vld = 1'b0;
      chk("ar_push_accept", 32'(ok), 32'd1);
   endtask

   task automatic r_drive(input int id, input logic last, input logic [1:0] resp,
                          input logic fwd, input logic exp_last);
      logic [DW-1:0] d;
      for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom;
      m_rid_i    = IW'(id);
      m_rdata_i  = d;
      m_rlast_i  = last;
      m_rresp_i  = resp;
      m_rvalid_i = 1'b1;
      if (fwd) sb.push_back({CW'(id), d, exp_last});
   endtask

   task automatic r_wait();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = m_rready_o;
         if (!ok) @(posedge clk);
      end
      @(posedge clk); #1;
      m_rvalid_i = 1'b0;
      chk("r_accept", 32'(ok), 32'd1);
   endtask

   task automatic r_beat(input int id, input logic last, input logic [1:0] resp,
                         input logic fwd, input logic exp_last);
      r_drive(id, last, resp, fwd, exp_last);
      r_wait();
   endtask

   task automatic clr_pulse(input int c);
      err_clr = '0;
      err_clr[c] = 1'b1;
      @(posedge clk); #1;
      err_clr = '0;
   endtask

   initial begin
      rst = 1'b1; atx_chn_id = '0; atx_arlen = '0; atx_vld = 1'b0;
      m_rid_i = '0; m_rdata_i = '0; m_rresp_i = '0; m_rlast_i = 1'b0; m_rvalid_i = 1'b0;
      out_rdy = 1'b1; err_clr = '0;
      repeat (2) @(posedge clk); #1;
      chk("rst_atx_rdy", 32'(atx_rdy), 32'd0);
      chk("rst_rready", 32'(m_rready_o), 32'd0);
      chk("rst_out_vld", 32'(out_vld), 32'd0);
      chk("rst_ostd", 32'(chn_ostd), 32'd0);
      chk("rst_err", 32'(chn_err), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_atx_rdy", 32'(atx_rdy), 32'd1);

      // single burst ch2, 4 beats
      ar_push(2, 3);
      chk("t1_ostd_push", 32'(ostd_of(2)), 32'd1);
      for (int b = 0; b < 4; b++) r_beat(2, b == 3, 2'b00, 1'b1, b == 3);
      chk("t1_ostd_pop", 32'(ostd_of(2)), 32'd0);
      chk("t1_err", 32'(err_of(2)), 32'd0);

      // interleaved ch0 (2 beats) and ch1 (3 beats)
      ar_push(0, 1);
      ar_push(1, 2);
      r_beat(0, 1'b0, 2'b00, 1'b1, 1'b0);
      r_beat(1, 1'b0, 2'b00, 1'b1, 1'b0);
      r_beat(0, 1'b1, 2'b00, 1'b1, 1'b1);
      r_beat(1, 1'b0, 2'b00, 1'b1, 1'b0);
      r_beat(1, 1'b1, 2'b00, 1'b1, 1'b1);
      chk("t2_ostd", 32'(chn_ostd), 32'd0);
      chk("t2_err", 32'(chn_err), 32'd0);

      // early RLAST on ch3
      ar_push(3, 1);
      r_beat(3, 1'b1, 2'b00, 1'b1, 1'b0);
      chk("t3_err_mismatch", 32'(err_of(3)), 32'd2);
      r_beat(3, 1'b0, 2'b00, 1'b1, 1'b1);
      chk("t3_ostd", 32'(ostd_of(3)), 32'd0);
      chk("t3_err_sticky", 32'(err_of(3)), 32'd2);
      clr_pulse(3);
      chk("t3_err_clr", 32'(err_of(3)), 32'd0);

      // unexpected beat, RRESP error, priority and clear-vs-new on ch1
      r_beat(1, 1'b1, 2'b10, 1'b0, 1'b0);
      chk("t4_err_unexp", 32'(err_of(1)), 32'd3);
      chk("t4_ostd", 32'(ostd_of(1)), 32'd0);
      clr_pulse(1);
      ar_push(1, 0);
      r_beat(1, 1'b1, 2'b00, 1'b1, 1'b1);
      chk("t4_err_clean", 32'(err_of(1)), 32'd0);
      ar_push(1, 0);
      r_beat(1, 1'b1, 2'b10, 1'b1, 1'b1);
      chk("t4_err_rresp", 32'(err_of(1)), 32'd1);
      ar_push(1, 1);
      r_beat(1, 1'b1, 2'b11, 1'b1, 1'b0);
      chk("t4_err_sticky", 32'(err_of(1)), 32'd1);
      r_beat(1, 1'b1, 2'b00, 1'b1, 1'b1);
      err_clr = 4'b0010;
      r_drive(1, 1'b0, 2'b00, 1'b0, 1'b0);
      r_wait();
      err_clr = '0;
      chk("t4_clr_vs_new", 32'(err_of(1)), 32'd3);
      clr_pulse(1);
      ar_push(1, 1);
      r_beat(1, 1'b1, 2'b10, 1'b1, 1'b0);
      chk("t4_prio_10_over_01", 32'(err_of(1)), 32'd2);
      r_beat(1, 1'b1, 2'b00, 1'b1, 1'b1);
      clr_pulse(1);
      chk("t4_err_final", 32'(chn_err), 32'd0);

      // full queue on ch0, then push + pop in the same cycle
      ar_push(0, 0);
      ar_push(0, 0);
      chk("t5_ostd_full", 32'(ostd_of(0)), 32'd2);
      atx_chn_id = 2'd0;
      @(negedge clk);
      chk("t5_rdy_ch0_full", 32'(atx_rdy), 32'd0);
      atx_chn_id = 2'd1;
      #1;
      chk("t5_rdy_ch1", 32'(atx_rdy), 32'd1);
      @(posedge clk); #1;
      atx_chn_id = 2'd0; atx_arlen = '0; atx_vld = 1'b1;
      r_drive(0, 1'b1, 2'b00, 1'b1, 1'b1);
      @(negedge clk);
      chk("t5_rdy_push_pop", 32'(atx_rdy), 32'd1);
      chk("t5_rready_push_pop", 32'(m_rready_o), 32'd1);
      @(posedge clk); #1;
      atx_vld = 1'b0; m_rvalid_i = 1'b0;
      chk("t5_ostd_same", 32'(ostd_of(0)), 32'd2);
      r_beat(0, 1'b1, 2'b00, 1'b1, 1'b1);
      r_beat(0, 1'b1, 2'b00, 1'b1, 1'b1);
      chk("t5_ostd_drain", 32'(ostd_of(0)), 32'd0);

      // output backpressure mid-burst on ch2
      ar_push(2, 3);
      out_rdy = 1'b0;
`ifdef ADMA_R_OUT_PIPE_EN
      r_beat(2, 1'b0, 2'b00, 1'b1, 1'b0);
      r_beat(2, 1'b0, 2'b00, 1'b1, 1'b0);
      sent = 3;
`else
      sent = 1;
`endif
      r_drive(2, 1'b0, 2'b00, 1'b1, 1'b0);
      @(negedge clk);
      chk("t6_rready_low", 32'(m_rready_o), 32'd0);
      repeat (3) @(posedge clk); #1;
      out_rdy = 1'b1;
      r_wait();
      for (int b = sent; b < 4; b++) r_beat(2, b == 3, 2'b00, 1'b1, b == 3);
      chk("t6_ostd", 32'(ostd_of(2)), 32'd0);
      chk("t6_err", 32'(err_of(2)), 32'd0);

      // reset mid-burst discards state
      ar_push(1, 3);
      r_beat(1, 1'b0, 2'b00, 1'b1, 1'b0);
      repeat (3) @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t7_ostd_reset", 32'(ostd_of(1)), 32'd0);
      r_beat(1, 1'b0, 2'b00, 1'b0, 1'b0);
      chk("t7_err_after_reset", 32'(err_of(1)), 32'd3);

      repeat (5) @(posedge clk); #1;
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
